frame_scanner: RTL and testbench

FRAME_SCANNER -- requirements
Module: frame_scanner

---
 rtl/frame_scanner.sv | 146 ++++++++++++++
 tb/tb_frame_scanner.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/frame_scanner.sv
// Raster-order frame reader: fetches width*height pixels from frame memory and streams them
// with coordinates and frame flags. Optional FRAME_SCANNER_LOOP_EN rescans the frame continuously.
module frame_scanner #(
  parameter int DATA_WIDTH_8  = 8,
  parameter int DATA_WIDTH_12 = 12,
  parameter int ADDR_WIDTH    = 20
) (
  input  logic                     clk_os,
  input  logic                     reset_os,
  input  logic                     start,
  input  logic [DATA_WIDTH_12-1:0] frame_src_width,
  input  logic [DATA_WIDTH_12-1:0] frame_src_height,
  output logic                     o_rd_en,
  output logic [ADDR_WIDTH-1:0]    o_rd_addr,
  input  logic [DATA_WIDTH_8-1:0]  rd_data,
  output logic [DATA_WIDTH_8-1:0]  o_pixel,
  output logic [DATA_WIDTH_12-1:0] o_xcoord,
  output logic [DATA_WIDTH_12-1:0] o_ycoord,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic                     o_sof,
  output logic                     o_eol,
  output logic                     o_eof,
  output logic                     o_busy,
  output logic                     o_done
);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

  typedef struct packed {
    logic [DATA_WIDTH_8-1:0]  pix;
    logic [DATA_WIDTH_12-1:0] x;
    logic [DATA_WIDTH_12-1:0] y;
  } ent_t;

  localparam logic [DATA_WIDTH_12-1:0] ONE = DATA_WIDTH_12'(1);

  state_t                   state, nxt;
  logic [DATA_WIDTH_12-1:0] w_q, h_q, rd_x, rd_y, rsp_x, rsp_y;
  logic [ADDR_WIDTH-1:0]    rd_addr;
  logic                     rsp_vld;
  ent_t                     buf_q [2];
  logic [1:0]               cnt;
  ent_t                     head, rsp_ent;
  logic                     accept, issue, last_rd, xfer, bypass, push, pop, last_xfer;

  assign accept    = (state == IDLE) && start && (frame_src_width != '0) && (frame_src_height != '0);
  // Buffered pixels plus the read still in flight may never exceed the two buffer slots.
  assign issue     = (state == FETCH) && ((cnt + {1'b0, rsp_vld}) < 2'd2);
  assign last_rd   = (rd_x == w_q - ONE) && (rd_y == h_q - ONE);
  assign rsp_ent   = '{pix: rd_data, x: rsp_x, y: rsp_y};

  // Returning read data bypasses the empty buffer so the first pixel appears one cycle after the read.
  always_comb begin
    head = '0;
    if (cnt != 2'd0)  head = buf_q[0];
    else if (rsp_vld) head = rsp_ent;
  end

  assign o_valid   = (cnt != 2'd0) || rsp_vld;
  assign o_pixel   = head.pix;
  assign o_xcoord  = head.x;
  assign o_ycoord  = head.y;
  assign o_sof     = o_valid && (head.x == '0) && (head.y == '0);
  assign o_eol     = o_valid && (head.x == w_q - ONE);
  assign o_eof     = o_eol && (head.y == h_q - ONE);
  assign o_rd_addr = rd_addr;

  assign xfer      = o_valid && i_ready;
  assign bypass    = (cnt == 2'd0) && rsp_vld && i_ready;
  assign push      = rsp_vld && !bypass;
  assign pop       = (cnt != 2'd0) && i_ready;
  assign last_xfer = xfer && o_eof;

  always_ff @(posedge clk_os or negedge reset_os) begin
    if (!reset_os) state <= IDLE;
    else           state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:  if (accept) nxt = FETCH;
      FETCH: if (issue && last_rd) nxt = DRAIN;
      DRAIN: if (last_xfer) nxt = DONE;
`ifdef FRAME_SCANNER_LOOP_EN
      DONE:  nxt = FETCH;
`else
      DONE:  nxt = IDLE;
`endif
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    o_busy  = (state != IDLE);
    o_done  = (state == DONE);
    o_rd_en = issue;
  end

  always_ff @(posedge clk_os or negedge reset_os) begin
    if (!reset_os) begin
      w_q      <= '0;
      h_q      <= '0;
      rd_x     <= '0;
      rd_y     <= '0;
      rd_addr  <= '0;
      rsp_x    <= '0;
      rsp_y    <= '0;
      rsp_vld  <= 1'b0;
      cnt      <= '0;
      buf_q[0] <= '0;
      buf_q[1] <= '0;
    end else begin
      rsp_vld <= issue;
      if (accept) begin
        w_q <= frame_src_width;
        h_q <= frame_src_height;
      end
      if (issue) begin
        rsp_x   <= rd_x;
        rsp_y   <= rd_y;
        rd_addr <= rd_addr + ADDR_WIDTH'(1);
        if (rd_x == w_q - ONE) begin
          rd_x <= '0;
          rd_y <= rd_y + ONE;
        end else begin
          rd_x <= rd_x + ONE;
        end
      end
      if (accept || state == DONE) begin
        rd_x    <= '0;
        rd_y    <= '0;
        rd_addr <= '0;
      end
      cnt <= cnt + {1'b0, push} - {1'b0, pop};
      if (pop) buf_q[0] <= buf_q[1];
      // Write position accounts for a same-cycle pop shifting the queue down.
      if (push) begin
        if (cnt == 2'd0 || (cnt == 2'd1 && pop)) buf_q[0] <= rsp_ent;
        else                                     buf_q[1] <= rsp_ent;
      end
    end
  end

endmodule

// File: tb/tb_frame_scanner.sv
// Bench for frame_scanner: table of frames plus random frames, checked against a raster-order
// reference model; hand sequences for reset, zero dimensions and FRAME_SCANNER_LOOP_EN.
module tb_frame_scanner;
  logic        clk_os = 1'b0, reset_os = 1'b0, start = 1'b0, i_ready = 1'b0;
  logic [11:0] frame_src_width = '0, frame_src_height = '0;
  logic        o_rd_en, o_valid, o_sof, o_eol, o_eof, o_busy, o_done;
  logic [19:0] o_rd_addr;
  logic [7:0]  rd_data = '0, o_pixel;
  logic [11:0] o_xcoord, o_ycoord;

  frame_scanner dut (
    .clk_os(clk_os), .reset_os(reset_os), .start(start),
    .frame_src_width(frame_src_width), .frame_src_height(frame_src_height),
    .o_rd_en(o_rd_en), .o_rd_addr(o_rd_addr), .rd_data(rd_data),
    .o_pixel(o_pixel), .o_xcoord(o_xcoord), .o_ycoord(o_ycoord), .o_valid(o_valid),
    .i_ready(i_ready), .o_sof(o_sof), .o_eol(o_eol), .o_eof(o_eof),
    .o_busy(o_busy), .o_done(o_done)
  );

  always #5 clk_os = ~clk_os;

  int errors = 0, checks = 0, cyc = 0;
  always @(posedge clk_os) cyc <= cyc + 1;

  // Frame memory: registered read, garbage on cycles without a read.
  logic [7:0] mem [256];
  always @(posedge clk_os) rd_data <= o_rd_en ? mem[o_rd_addr[7:0]] : 8'($urandom);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // i_ready driver: 0 = always ready, 1 = repeating 1,0,0,1, 2 = random.
  int         rdy_mode = 0, pcnt = 0;
  logic [3:0] pat = 4'b1001;
  initial forever begin
    @(posedge clk_os); #1;
    case (rdy_mode)
      0:       i_ready = 1'b1;
      1:       begin i_ready = pat[pcnt % 4]; pcnt++; end
      default: i_ready = 1'($urandom % 2);
    endcase
  end

  // Reference model: pixel i of a w x h frame sits at (i % w, i / w) and comes from mem[i].
  bit          mon_on = 0, done_due = 0, prev_stall = 0;
  int          mw = 1, mh = 1, exp_idx = 0, rd_idx = 0, outst = 0, xfer_cnt = 0, done_cnt = 0;
  int          first_rd = -1, first_vld = -1, done_cyc = -1;
  logic [35:0] snap;

  always @(negedge clk_os) begin
    if (!mon_on) begin
      prev_stall = 0; done_due = 0; outst = 0;
    end else begin
      if (prev_stall)
        chk("stall_hold", {o_valid, o_pixel, o_xcoord, o_ycoord, o_sof, o_eol, o_eof}, snap);
      if (o_done || done_due) chk("done_timing", o_done, done_due);
      done_due = 0;
      if (o_done) begin done_cnt++; done_cyc = cyc; end
      if (o_rd_en) begin
        chk("rd_addr", o_rd_addr, rd_idx);
        rd_idx = (rd_idx + 1) % (mw * mh);
        outst++;
        if (first_rd < 0) first_rd = cyc;
        chk("outstanding_le2", outst <= 2, 1);
      end
      if (o_valid && i_ready) begin
        chk("pixel", o_pixel, mem[exp_idx]);
        chk("xcoord", o_xcoord, exp_idx % mw);
        chk("ycoord", o_ycoord, exp_idx / mw);
        chk("flags_sof_eol_eof", {o_sof, o_eol, o_eof},
            {exp_idx == 0, (exp_idx % mw) == mw - 1, exp_idx == mw * mh - 1});
        if (first_vld < 0) first_vld = cyc;
        outst--; xfer_cnt++; exp_idx++;
        if (exp_idx == mw * mh) begin exp_idx = 0; done_due = 1; end
      end
      prev_stall = o_valid && !i_ready;
      snap = {o_valid, o_pixel, o_xcoord, o_ycoord, o_sof, o_eol, o_eof};
    end
  end

  task automatic chk_all_zero(input string name);
    chk(name, {o_valid, o_rd_en, o_busy, o_done, o_sof, o_eol, o_eof,
               o_pixel, o_xcoord, o_ycoord, o_rd_addr}, 64'd0);
  endtask

  // Start a frame; for accepted frames wait for o_done and check count and latency.
  task automatic run_frame(input int w, input int h, input int mode, input bit acc);
    int  t0, d0, busy_seen, quiet;
    rdy_mode = mode; mw = (w == 0) ? 1 : w; mh = (h == 0) ? 1 : h;
    exp_idx = 0; rd_idx = 0; xfer_cnt = 0; first_rd = -1; first_vld = -1; done_cyc = -1;
    d0 = done_cnt;
    mon_on = acc;
    @(posedge clk_os); #1;
    start = 1'b1; frame_src_width = 12'(w); frame_src_height = 12'(h); t0 = cyc;
    @(posedge clk_os); #1;
    start = 1'b0; frame_src_width = 12'($urandom); frame_src_height = 12'($urandom);
    @(negedge clk_os);
    busy_seen = o_busy;
    chk("accept", busy_seen, acc);
    if (!acc) begin
      quiet = 0;
      for (int k = 0; k < 10; k++) begin
        @(negedge clk_os);
        quiet = quiet | o_busy | o_rd_en | o_done;
      end
      chk("zero_dim_quiet", quiet, 0);
      return;
    end
    // A start while busy, with other dimensions, must be ignored.
    @(posedge clk_os); #1;
    start = 1'b1; frame_src_width = 12'd1; frame_src_height = 12'd1;
    @(posedge clk_os); #1;
    start = 1'b0;
    for (int k = 0; k < w * h * 8 + 50; k++) begin
      if (done_cnt != d0) break;
      @(posedge clk_os);
    end
    chk("done_seen", done_cnt - d0, 1);
    chk("xfer_count", xfer_cnt, w * h);
    if (mode == 0) begin
      chk("lat_rd_en", first_rd - t0, 1);
      chk("lat_valid", first_vld - t0, 2);
      chk("lat_done", done_cyc - t0, w * h + 2);
    end
`ifndef FRAME_SCANNER_LOOP_EN
    @(negedge clk_os);
    chk("idle_after_done", o_busy, 0);
`endif
  endtask

  typedef struct { int w; int h; int mode; bit acc; } vec_t;
  vec_t tbl [8];

  initial begin
    tbl[0] = '{4, 3, 0, 1};
    tbl[1] = '{4, 3, 1, 1};
    tbl[2] = '{0, 5, 0, 0};
    tbl[3] = '{1, 1, 0, 1};
    tbl[4] = '{1, 5, 1, 1};
    tbl[5] = '{5, 1, 2, 1};
    tbl[6] = '{7, 4, 2, 1};
    tbl[7] = '{5, 0, 0, 0};
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < 12; i++) mem[i] = 8'(i);
    mem[0] = 8'hA5;

    #1 chk_all_zero("reset_outputs");
    repeat (3) @(posedge clk_os);
    #1 reset_os = 1'b1;

`ifndef FRAME_SCANNER_LOOP_EN
    foreach (tbl[i]) run_frame(tbl[i].w, tbl[i].h, tbl[i].mode, tbl[i].acc);
    for (int i = 0; i < 6; i++)
      run_frame(int'($urandom_range(1, 9)), int'($urandom_range(1, 6)), int'($urandom_range(0, 2)), 1);
`else
    run_frame(0, 5, 0, 0);
    begin
      int d0, busy_low;
      rdy_mode = 2; mw = 2; mh = 2; exp_idx = 0; rd_idx = 0; xfer_cnt = 0; busy_low = 0;
      mon_on = 1; d0 = done_cnt;
      @(posedge clk_os); #1;
      start = 1'b1; frame_src_width = 12'd2; frame_src_height = 12'd2;
      @(posedge clk_os); #1;
      start = 1'b0;
      for (int k = 0; k < 200; k++) begin
        if (done_cnt - d0 >= 3) break;
        @(negedge clk_os);
        busy_low = busy_low | !o_busy;
      end
      chk("loop_frames", done_cnt - d0 >= 3, 1);
      chk("loop_xfers_ge_12", xfer_cnt >= 12, 1);
      chk("loop_busy_stays", busy_low, 0);
    end
`endif

    // Reset in the middle of an 8x8 frame, asserted away from any clock edge.
    mon_on = 1; rdy_mode = 0; mw = 8; mh = 8; exp_idx = 0; rd_idx = 0; xfer_cnt = 0;
    @(posedge clk_os); #1;
    start = 1'b1; frame_src_width = 12'd8; frame_src_height = 12'd8;
    @(posedge clk_os); #1;
    start = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (xfer_cnt >= 5) break;
      @(posedge clk_os);
    end
    chk("reached_pixel5", xfer_cnt >= 5, 1);
    #2 reset_os = 1'b0; mon_on = 0;
    #1 chk_all_zero("async_reset_outputs");
    repeat (2) @(posedge clk_os);
    #1 reset_os = 1'b1;
    begin
      int stray;
      stray = 0;
      for (int k = 0; k < 4; k++) begin
        @(negedge clk_os);
        stray = stray | o_valid | o_busy | o_rd_en;
      end
      chk("post_reset_quiet", stray, 0);
    end
    run_frame(8, 8, 2, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
